// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg -- shared types and constants for the instruction fetch controller.
//   fetch_state_e    : controller state encoding
//   SEL_SEQ/JAL/JALR : one-hot next-pc source selects
//   RESET_PC_DEFAULT : default first fetch address after reset
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  localparam logic [2:0] SEL_SEQ  = 3'b001;
  localparam logic [2:0] SEL_JAL  = 3'b010;
  localparam logic [2:0] SEL_JALR = 3'b100;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

  // Only jal and jalr selects may redirect; every other pattern is ignored.
  function automatic logic sel_is_redirect(input logic [2:0] sel);
    return (sel == SEL_JAL) || (sel == SEL_JALR);
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc -- combinational next-pc computation (all sums modulo 2^XLEN).
//   fetch_pc_i  : current fetch address (sequential base)
//   sel_i       : one-hot source select (SEL_JAL / SEL_JALR, anything else -> seq)
//   redir_pc_i  : jal base, rs1_i : jalr base, imm_i : immediate
//   seq_pc_o    : fetch_pc_i + 4
//   target_o    : selected target, misalign_o : target bit[1] set
module fetch_next_pc
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] fetch_pc_i,
  input  logic [2:0]      sel_i,
  input  logic [XLEN-1:0] redir_pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] seq_pc_o,
  output logic [XLEN-1:0] target_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] jal_pc;
  logic [XLEN-1:0] jalr_sum;

  assign seq_pc_o = fetch_pc_i + XLEN'(4);
  // jal immediate is a half-word offset
  assign jal_pc   = redir_pc_i + {imm_i[XLEN-2:0], 1'b0};
  assign jalr_sum = rs1_i + imm_i;

  always_comb begin
    target_o = seq_pc_o;
    case (sel_i)
      SEL_JAL:  target_o = jal_pc;
      SEL_JALR: target_o = {jalr_sum[XLEN-1:1], 1'b0};
      default:  target_o = seq_pc_o;
    endcase
  end

  assign misalign_o = target_o[1];

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction fetch controller with one outstanding imem request
// and a one-entry instruction buffer toward decode.
//   clk, rst_n                     : clock, async active-low reset
//   redir_valid_i/sel_i/pc_i/rs1_i/imm_i : jump redirect request
//   imem_req_valid_o/ready_i/addr_o     : fetch request handshake
//   imem_rsp_valid_i/data_i             : fetch response (no backpressure)
//   inst_valid_o/ready_i, inst_o, inst_pc_o : instruction to decode
//   fault_o                        : sticky misaligned-redirect flag
// Optional build macro: FETCH_CTRL_MISALIGN_EN enables the misaligned-target
// check (fault + HALT). Without it fault_o stays 0 and HALT is unreachable.
//
// state    | meaning
// IDLE     | first cycle after reset, no request
// REQ      | presenting fetch_pc to imem (when buffer free or draining)
// WAIT     | request accepted, waiting for its response
// FLUSH    | redirected while a response is outstanding; drop it
// HALT     | misaligned redirect seen; fetching stopped until reset
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redir_valid_i,
  input  logic [2:0]      redir_sel_i,
  input  logic [XLEN-1:0] redir_pc_i,
  input  logic [XLEN-1:0] redir_rs1_i,
  input  logic [XLEN-1:0] redir_imm_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            fault_o
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic            inst_valid_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            fault_q;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] target;
  logic            misalign;
  logic            redir_ok;
  logic            redir_bad;
  logic            fire;
  logic            deq;

  fetch_next_pc #(.XLEN(XLEN)) u_next_pc (
    .fetch_pc_i (fetch_pc_q),
    .sel_i      (redir_sel_i),
    .redir_pc_i (redir_pc_i),
    .rs1_i      (redir_rs1_i),
    .imm_i      (redir_imm_i),
    .seq_pc_o   (seq_pc),
    .target_o   (target),
    .misalign_o (misalign)
  );

  assign redir_ok = redir_valid_i && sel_is_redirect(redir_sel_i);

`ifdef FETCH_CTRL_MISALIGN_EN
  assign redir_bad = redir_ok && misalign;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign redir_bad       = 1'b0;
`endif

  assign deq = inst_valid_q && inst_ready_i;
  // Request only when the buffer will have room for the response.
  assign imem_req_valid_o = (state_q == ST_REQ) && (!inst_valid_q || inst_ready_i);
  assign imem_req_addr_o  = fetch_pc_q;
  assign fire             = imem_req_valid_o && imem_req_ready_i;

  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign fault_o      = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      fault_q      <= 1'b0;
    end else begin
      if (deq) inst_valid_q <= 1'b0;

      if (redir_ok && (state_q != ST_HALT)) begin
        // Redirect beats every other event this cycle.
        inst_valid_q <= 1'b0;
        fetch_pc_q   <= target;
        if (redir_bad) begin
          fault_q <= 1'b1;
          state_q <= ST_HALT;
        end else begin
          case (state_q)
            ST_IDLE:  state_q <= ST_REQ;
            ST_REQ:   state_q <= fire ? ST_FLUSH : ST_REQ;
            ST_WAIT:  state_q <= imem_rsp_valid_i ? ST_REQ : ST_FLUSH;
            ST_FLUSH: state_q <= imem_rsp_valid_i ? ST_REQ : ST_FLUSH;
            default:  state_q <= state_q;
          endcase
        end
      end else begin
        case (state_q)
          ST_IDLE:  state_q <= ST_REQ;
          ST_REQ:   if (fire) state_q <= ST_WAIT;
          ST_WAIT: begin
            if (imem_rsp_valid_i) begin
              inst_valid_q <= 1'b1;
              inst_q       <= imem_rsp_data_i;
              inst_pc_q    <= fetch_pc_q;
              fetch_pc_q   <= seq_pc;
              state_q      <= ST_REQ;
            end
          end
          ST_FLUSH: if (imem_rsp_valid_i) state_q <= ST_REQ;
          default:  state_q <= state_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        redir_valid_i;
  logic [2:0]  redir_sel_i;
  logic [63:0] redir_pc_i;
  logic [63:0] redir_rs1_i;
  logic [63:0] redir_imm_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        fault_o;

  fetch_ctrl #(.XLEN(64), .RESET_PC(64'h8000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redir_valid_i    (redir_valid_i),
    .redir_sel_i      (redir_sel_i),
    .redir_pc_i       (redir_pc_i),
    .redir_rs1_i      (redir_rs1_i),
    .redir_imm_i      (redir_imm_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .fault_o          (fault_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int fire_cnt = 0;

  // imem model: responds rsp_lat cycles after acceptance, one outstanding.
  int          rsp_lat = 1;
  int          pend    = 0;
  logic [63:0] pend_addr;

  logic [63:0] exp_req[$];
  logic [63:0] exp_pc[$];

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // One clock: score handshakes seen before the edge, then advance the imem model.
  task automatic step();
    logic        fire;
    logic        deq;
    logic [63:0] a;
    logic [63:0] e;
    #1;
    fire = imem_req_valid_o && imem_req_ready_i && rst_n;
    deq  = inst_valid_o && inst_ready_i && rst_n;
    a    = imem_req_addr_o;
    if (fire) begin
      fire_cnt++;
      n_checks++;
      if (exp_req.size() == 0) begin
        n_fail++;
        $display("FAIL req_unexpected: addr=%h issued, no request required", a);
      end else begin
        e = exp_req.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL req_addr: got %h required %h", a, e);
        end
      end
    end
    if (deq) begin
      n_checks++;
      if (exp_pc.size() == 0) begin
        n_fail++;
        $display("FAIL inst_unexpected: pc=%h inst=%h delivered, none required", inst_pc_o, inst_o);
      end else begin
        e = exp_pc.pop_front();
        if (inst_pc_o !== e || inst_o !== mem_data(e)) begin
          n_fail++;
          $display("FAIL inst: got pc=%h inst=%h required pc=%h inst=%h",
                   inst_pc_o, inst_o, e, mem_data(e));
        end
      end
    end
    @(posedge clk);
    #1;
    imem_rsp_valid_i = 1'b0;
    if (fire) begin
      pend      = rsp_lat;
      pend_addr = a;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = mem_data(pend_addr);
      end
    end
  endtask

  task automatic run_until_empty(input int max_cycles, input string name);
    int n = 0;
    while ((exp_req.size() != 0 || exp_pc.size() != 0) && n < max_cycles) begin
      imem_req_ready_i = (exp_req.size() != 0);
      step();
      n++;
    end
    imem_req_ready_i = 1'b0;
    n_checks++;
    if (exp_req.size() != 0 || exp_pc.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d requests / %0d insts outstanding, required 0",
               name, exp_req.size(), exp_pc.size());
      exp_req.delete();
      exp_pc.delete();
    end
  endtask

  task automatic wait_fire(input int max_cycles, input string name);
    int start = fire_cnt;
    int n = 0;
    while (fire_cnt == start && n < max_cycles) begin
      step();
      n++;
    end
    n_checks++;
    if (fire_cnt == start) begin
      n_fail++;
      $display("FAIL %s_no_request: 0 requests accepted, required 1", name);
    end
  endtask

  task automatic clear_redir();
    redir_valid_i = 1'b0;
    redir_sel_i   = 3'b000;
    redir_pc_i    = '0;
    redir_rs1_i   = '0;
    redir_imm_i   = '0;
  endtask

  task automatic apply_reset();
    rst_n            = 1'b0;
    clear_redir();
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    inst_ready_i     = 1'b1;
    rsp_lat          = 1;
    pend             = 0;
    exp_req.delete();
    exp_pc.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== 32'h0 ||
        inst_pc_o !== 64'h0 || fault_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: req_v=%b inst_v=%b inst=%h pc=%h fault=%b required all 0",
               imem_req_valid_o, inst_valid_o, inst_o, inst_pc_o, fault_o);
    end
    imem_req_ready_i = 1'b1;
    #1;
    n_checks++;
    if (imem_req_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: req_valid=%b required 0", imem_req_valid_o);
    end
    step();
    n_checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 64'h8000_0000) begin
      n_fail++;
      $display("FAIL first_req: valid=%b addr=%h required 1 / 80000000",
               imem_req_valid_o, imem_req_addr_o);
    end
    imem_req_ready_i = 1'b0;
  endtask

  task automatic test_sequential();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      exp_req.push_back(64'h8000_0000 + 64'(4 * i));
      exp_pc.push_back(64'h8000_0000 + 64'(4 * i));
    end
    run_until_empty(40, "seq");
  endtask

  task automatic test_stall();
    int n = 0;
    apply_reset();
    exp_req.push_back(64'h8000_0000);
    exp_req.push_back(64'h8000_0004);
    exp_pc.push_back(64'h8000_0000);
    exp_pc.push_back(64'h8000_0004);
    inst_ready_i     = 1'b0;
    imem_req_ready_i = 1'b1;
    while (inst_valid_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b1 ||
          inst_pc_o !== 64'h8000_0000 || inst_o !== mem_data(64'h8000_0000)) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: req_v=%b inst_v=%b pc=%h inst=%h required 0/1/80000000/%h",
                 i, imem_req_valid_o, inst_valid_o, inst_pc_o, inst_o, mem_data(64'h8000_0000));
      end
      step();
    end
    inst_ready_i = 1'b1;
    run_until_empty(40, "stall");
  endtask

  task automatic test_jal_flush();
    apply_reset();
    rsp_lat          = 3;
    imem_req_ready_i = 1'b1;
    exp_req.push_back(64'h8000_0000);
    wait_fire(10, "jal");
    imem_req_ready_i = 1'b0;
    redir_valid_i = 1'b1;
    redir_sel_i   = 3'b010;
    redir_pc_i    = 64'h8000_0010;
    redir_imm_i   = 64'h8;
    step();
    clear_redir();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL jal_flush_quiet[%0d]: req_v=%b inst_v=%b required 0/0",
                 i, imem_req_valid_o, inst_valid_o);
      end
      step();
    end
    exp_req.push_back(64'h8000_0020);
    exp_pc.push_back(64'h8000_0020);
    run_until_empty(40, "jal");
  endtask

  task automatic test_jalr_with_rsp();
    apply_reset();
    rsp_lat          = 1;
    imem_req_ready_i = 1'b1;
    exp_req.push_back(64'h8000_0000);
    wait_fire(10, "jalr");
    imem_req_ready_i = 1'b0;
    n_checks++;
    if (imem_rsp_valid_i !== 1'b1) begin
      n_fail++;
      $display("FAIL jalr_setup: rsp_valid=%b required 1", imem_rsp_valid_i);
    end
    redir_valid_i = 1'b1;
    redir_sel_i   = 3'b100;
    redir_rs1_i   = 64'h8000_0101;
    redir_imm_i   = 64'h2;
    step();
    clear_redir();
`ifdef FETCH_CTRL_MISALIGN_EN
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (fault_o !== 1'b1 || imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL jalr_halt[%0d]: fault=%b req_v=%b inst_v=%b required 1/0/0",
                 i, fault_o, imem_req_valid_o, inst_valid_o);
      end
      imem_req_ready_i = 1'b1;
      step();
    end
    imem_req_ready_i = 1'b0;
`else
    exp_req.push_back(64'h8000_0102);
    exp_pc.push_back(64'h8000_0102);
    run_until_empty(40, "jalr");
`endif
  endtask

  task automatic test_misalign();
    logic [2:0] bad_sel[2];
    bad_sel[0] = 3'b011;
    bad_sel[1] = 3'b001;
    apply_reset();
    step();
    foreach (bad_sel[i]) begin
      redir_valid_i = 1'b1;
      redir_sel_i   = bad_sel[i];
      redir_pc_i    = 64'h1000;
      redir_rs1_i   = 64'h2000;
      redir_imm_i   = 64'h40;
      step();
      clear_redir();
      #1;
      n_checks++;
      if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 64'h8000_0000) begin
        n_fail++;
        $display("FAIL illegal_sel_%b: valid=%b addr=%h required 1 / 80000000",
                 bad_sel[i], imem_req_valid_o, imem_req_addr_o);
      end
    end
    redir_valid_i = 1'b1;
    redir_sel_i   = 3'b100;
    redir_rs1_i   = 64'h8000_0004;
    redir_imm_i   = 64'h2;
    step();
    clear_redir();
`ifdef FETCH_CTRL_MISALIGN_EN
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (fault_o !== 1'b1 || imem_req_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign_halt[%0d]: fault=%b req_v=%b required 1/0",
                 i, fault_o, imem_req_valid_o);
      end
      imem_req_ready_i = 1'b1;
      step();
    end
    imem_req_ready_i = 1'b0;
`else
    n_checks++;
    if (fault_o !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_nofault: fault=%b required 0", fault_o);
    end
    exp_req.push_back(64'h8000_0006);
    exp_pc.push_back(64'h8000_0006);
    run_until_empty(40, "misalign");
`endif
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    rsp_lat          = 5;
    imem_req_ready_i = 1'b1;
    exp_req.push_back(64'h8000_0000);
    wait_fire(10, "rstwait");
    imem_req_ready_i = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== 32'h0 ||
        inst_pc_o !== 64'h0 || fault_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: req_v=%b inst_v=%b inst=%h pc=%h fault=%b required all 0",
               imem_req_valid_o, inst_valid_o, inst_o, inst_pc_o, fault_o);
    end
    step();
    rst_n = 1'b1;
    step();
    // Late response from the pre-reset request lands while in REQ and must be ignored.
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 64'h8000_0000 || inst_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_req[%0d]: valid=%b addr=%h inst_v=%b required 1 / 80000000 / 0",
                 i, imem_req_valid_o, imem_req_addr_o, inst_valid_o);
      end
      step();
    end
    exp_req.push_back(64'h8000_0000);
    exp_pc.push_back(64'h8000_0000);
    run_until_empty(40, "rstwait");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_redir();
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    inst_ready_i     = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_jal_flush();
    test_jalr_with_rsp();
    test_misalign();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 64'h8000_0000, first fetch address after reset.
REQ-002 Parameter: XLEN, default 64, width of all address/operand ports.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 redir_valid_i  in  1  redirect request, one-cycle pulse per redirect.
REQ-006 redir_sel_i  in  3  one-hot: 010 jal, 100 jalr; any other value SHALL be ignored (no redirect).
REQ-007 redir_pc_i  in  XLEN  pc of the jump instruction (jal base).
REQ-008 redir_rs1_i  in  XLEN  rs1 operand (jalr base).
REQ-009 redir_imm_i  in  XLEN  immediate; jal uses it as half-word offset.
REQ-010 imem_req_valid_o  out  1  / imem_req_ready_i  in  1 / imem_req_addr_o  out  XLEN  fetch request handshake.
REQ-011 imem_rsp_valid_i  in  1 / imem_rsp_data_i  in  32  fetch response, no backpressure.
REQ-012 inst_valid_o  out  1 / inst_ready_i  in  1 / inst_o  out  32 / inst_pc_o  out  XLEN  instruction to decode.
REQ-013 fault_o  out  1  misaligned redirect target (see Configuration).

Function
REQ-014 Next-PC arithmetic, modulo 2^XLEN: seq = fetch_pc+4; jal = redir_pc_i+{redir_imm_i[XLEN-2:0],1'b0}; jalr = (redir_rs1_i+redir_imm_i) & ~1.
REQ-015 States: IDLE, REQ, WAIT, FLUSH, HALT; at most one imem request outstanding.
REQ-016 IDLE: exit to REQ on first cycle after reset release; no request issued in IDLE.
REQ-017 REQ: imem_req_valid_o=1, imem_req_addr_o=fetch_pc, when inst buffer empty or draining this cycle (inst_valid_o & inst_ready_i); on valid&ready go WAIT.
REQ-018 Once asserted, imem_req_valid_o and imem_req_addr_o SHALL stay stable until accepted, except withdrawn by a redirect.
REQ-019 WAIT: on imem_rsp_valid_i, load one-entry inst buffer (inst_o=data, inst_pc_o=fetch_pc), fetch_pc<=seq, go REQ; inst_valid_o=1 next cycle.
REQ-020 inst buffer holds until inst_valid_o & inst_ready_i; inst_o/inst_pc_o SHALL not change while inst_valid_o=1 and not accepted.
REQ-021 Redirect (valid, legal sel) has priority over all events: fetch_pc<=target next cycle, inst buffer invalidated next cycle.
REQ-022 Redirect in REQ with no handshake, or in IDLE: go/stay REQ, new address next cycle.
REQ-023 Redirect in WAIT without response, or in REQ coincident with handshake: go FLUSH; next response SHALL be dropped, then REQ.
REQ-024 Redirect in WAIT coincident with response: response dropped, go REQ.
REQ-025 Redirect in FLUSH: update fetch_pc, stay FLUSH until stale response arrives.
REQ-026 imem_rsp_valid_i in IDLE, REQ or HALT SHALL be ignored.

Reset
REQ-027 rst_n low: state=IDLE, fetch_pc=RESET_PC, all valids=0, inst_o=0, inst_pc_o=0, fault_o=0, asynchronously.
REQ-028 Reset mid-transaction discards outstanding request; first post-reset fetch is RESET_PC.

Configuration
REQ-029 Macro FETCH_CTRL_MISALIGN_EN defined: redirect target with bit[1]=1 SHALL set fault_o (sticky until reset), go HALT, issue no further requests (outstanding response dropped).
REQ-030 Macro undefined: no check, HALT unreachable, fault_o tied 0, target used as computed.

Structure
REQ-031 Shared package: state enum, pc_sel one-hot constants (SEL_SEQ 001, SEL_JAL 010, SEL_JALR 100), RESET_PC default.
REQ-032 One sub-module fetch_next_pc: combinational target computation of REQ-014 plus misalign flag.

Verification
REQ-033 Reset release, imem always ready, 1-cycle response, inst_ready=1 -> addresses 8000_0000, 8000_0004, 8000_0008 with matching inst_pc_o.
REQ-034 inst_ready_i=0 for 5 cycles with buffer full -> no new request, inst_o/inst_pc_o stable, resumes on ready.
REQ-035 jal redirect redir_pc=8000_0010, imm=8 during WAIT -> FLUSH, stale response dropped, next request 8000_0020.
REQ-036 jalr rs1=8000_0101, imm=2 coincident with response -> response dropped, next request 8000_0102.
REQ-037 With FETCH_CTRL_MISALIGN_EN, jalr target 8000_0006 -> fault_o=1, no further imem_req_valid_o; without macro -> fetch 8000_0006.
REQ-038 rst_n low while WAIT -> immediate IDLE, outputs reset; after release first request 8000_0000, late response ignored.
